// File: rtl/dict_pkg.sv
// Shared types and defaults for the dictionary init loader.
// Holds default widths, the table depth and the loader state encoding.
package dict_pkg;

    localparam int DEF_KEY_WIDTH = 4;
    localparam int DEF_VAL_WIDTH = 8;
    localparam int DICT_DEPTH    = 2 ** DEF_KEY_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

endpackage

// File: rtl/dict_load_buf.sv
// N x VAL_WIDTH table buffer: one synchronous write port, one registered read.
// Ports: clk, reset, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data.
module dict_load_buf
    import dict_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH,
    parameter int VAL_WIDTH = DEF_VAL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [KEY_WIDTH-1:0] wr_addr,
    input  logic [VAL_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [KEY_WIDTH-1:0] rd_addr,
    output logic [VAL_WIDTH-1:0] rd_data
);

    localparam int N = 2 ** KEY_WIDTH;

    // Table storage is deliberately not reset; every load rewrites it fully.
    logic [VAL_WIDTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data returns to zero whenever no read is issued, so the
    // output is quiet outside the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/dict_loader.sv
// Buffers a full dictionary table from a valid/ready stream, then replays it
// as one gap-free write burst. Ports: clk, reset, start, in_valid/in_ready/
// in_data (upstream), write_enable/write_val (dictionary), busy, done.
module dict_loader
    import dict_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH,
    parameter int VAL_WIDTH = DEF_VAL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VAL_WIDTH-1:0] in_data,
    output logic                 write_enable,
    output logic [VAL_WIDTH-1:0] write_val,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = 2 ** KEY_WIDTH;
    localparam int CW = KEY_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    load_state_e          state;
    logic [CW-1:0]        fill_cnt;
    logic [CW-1:0]        burst_cnt;
    logic                 hs;
    logic                 fill_last;
    logic                 burst_last;
    logic                 rd_en;
    logic [KEY_WIDTH-1:0] rd_addr;
    logic [VAL_WIDTH-1:0] rd_data;

    assign in_ready     = (state == ST_FILL);
    assign write_enable = (state == ST_BURST);
    assign busy         = (state == ST_FILL) || (state == ST_BURST);
    assign done         = (state == ST_DONE);

    assign hs         = in_valid && in_ready;
    assign fill_last  = (fill_cnt == LAST);
    assign burst_last = (burst_cnt == LAST);

    // Reads run one entry ahead of the burst: entry 0 is fetched on the
    // final fill handshake, entry k+1 during burst cycle k, so the
    // registered read lines up with write_enable.
    assign rd_en = (state == ST_FILL && hs && fill_last) ||
                   (state == ST_BURST && !burst_last);
    assign rd_addr = (state == ST_BURST) ?
                     burst_cnt[KEY_WIDTH-1:0] + KEY_WIDTH'(1) : '0;

    assign write_val = rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (hs) begin
                        fill_cnt <= fill_cnt + CW'(1);
                        if (fill_last) begin
                            state     <= ST_BURST;
                            burst_cnt <= '0;
                        end
                    end
                end
                ST_BURST: begin
                    burst_cnt <= burst_cnt + CW'(1);
                    if (burst_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dict_load_buf #(
        .KEY_WIDTH (KEY_WIDTH),
        .VAL_WIDTH (VAL_WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (hs),
        .wr_addr (fill_cnt[KEY_WIDTH-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_dict_loader.sv
// Directed bench for dict_loader with a behavioural dictionary model.
// Checks reset values, burst shape/data, latency, start/reset corner cases.
module tb_dict_loader;

    logic       clk = 0;
    logic       reset = 1;
    logic       start = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_data = 0;
    logic       write_enable;
    logic [7:0] write_val;
    logic       busy;
    logic       done;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dict_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .write_enable (write_enable),
        .write_val    (write_val),
        .busy         (busy),
        .done         (done)
    );

    // Dictionary model: write index clears whenever write_enable is low.
    logic [7:0] dict [16];
    int         widx = 0;
    logic [7:0] wq [$];
    int         runs = 0;
    int         viol = 0;
    logic       prev_we = 0;

    always @(negedge clk) begin
        if (write_enable) begin
            if (!prev_we) runs++;
            wq.push_back(write_val);
            if (widx < 16) dict[widx] = write_val;
            widx++;
        end else begin
            widx = 0;
        end
        prev_we = write_enable;
        if (in_ready && (!busy || write_enable || done)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int key_of(input logic [7:0] v);
        for (int i = 0; i < 16; i++) if (dict[i] === v) return i;
        return -1;
    endfunction

    task automatic feed(input logic [7:0] base, input bit bursty);
        int guard = 0;
        for (int k = 0; k < 16; k++) begin
            bit acc = 0;
            while (!acc && guard < 2000) begin
                in_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = base + 8'(k);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
        end
        in_valid = 0;
        if (guard >= 2000) check("feed_timeout", 1, 0);
    endtask

    task automatic check_burst(input string tag, input logic [7:0] base);
        int bad = 0;
        check({tag, "_runs"}, runs, 1);
        check({tag, "_len"}, wq.size(), 16);
        foreach (wq[i]) if (wq[i] !== base + 8'(i)) bad++;
        check({tag, "_data"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (dict[i] !== base + 8'(i)) bad++;
        check({tag, "_dict"}, bad, 0);
    endtask

    task automatic run_load(input logic [7:0] base, input bit bursty,
                            input bit poke, input int exp_lat);
        int n = 0;
        bit got = 0;
        bit pkb = 0;
        wq.delete();
        runs = 0;
        @(posedge clk);
        #1;
        start = 1;
        fork
            feed(base, bursty);
            begin
                while (!got && n < 600) begin
                    @(posedge clk);
                    #1;
                    n++;
                    start = 0;
                    if (n == 1) check("done_clr", done, 0);
                    if (poke && (n == 3 || (write_enable && !pkb))) begin
                        start = 1;
                        if (write_enable) pkb = 1;
                    end
                    if (done) got = 1;
                end
            end
        join
        check("done_seen", got, 1);
        if (exp_lat > 0) check("done_lat", n, exp_lat);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) dict[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_we", write_enable, 0);
        check("rst_wval", write_val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        run_load(8'hA0, 0, 0, 33);
        check_burst("b2b", 8'hA0);
        check("key5", dict[5], 8'hA5);
        check("val_af_key", key_of(8'hAF), 15);

        run_load(8'hA0, 1, 0, 0);
        check_burst("bursty", 8'hA0);

        run_load(8'h50, 0, 1, 33);
        check_burst("poke", 8'h50);

        wq.delete();
        runs = 0;
        n = 0;
        @(posedge clk);
        #1;
        start = 1;
        fork
            feed(8'hA0, 0);
            begin
                @(posedge clk);
                #1;
                start = 0;
                while (wq.size() < 7 && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        check("rst_reach7", wq.size(), 7);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        check("rstb_we", write_enable, 0);
        check("rstb_done", done, 0);
        check("rstb_busy", busy, 0);
        check("rstb_wval", write_val, 0);
        check("rstb_part", wq.size(), 8);

        run_load(8'h10, 0, 0, 33);
        check_burst("after_rst", 8'h10);
        check("key0_10", dict[0], 8'h10);

        run_load(8'hF0, 0, 0, 33);
        check_burst("reload", 8'hF0);
        check("key0_f0", dict[0], 8'hF0);

        @(posedge clk);
        #1;
        reset = 1;
        start = 1;
        @(posedge clk);
        #1;
        reset = 0;
        start = 0;
        @(posedge clk);
        @(negedge clk);
        check("rs_ready", in_ready, 0);
        check("rs_we", write_enable, 0);
        check("rs_wval", write_val, 0);
        check("rs_busy", busy, 0);
        check("rs_done", done, 0);

        check("ready_outside_fill", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
